// File: rtl/ppu_pixel_fifo_pkg.sv
// Shared types and helpers for the PPU pixel FIFO slice.
package ppu_pixel_fifo_pkg;

  localparam int PPU_TILE_W = 8;
  localparam int PPU_DEPTH  = 16;
  localparam int PPU_PX_W   = 2;

  typedef enum logic [1:0] {H_BLANK, V_BLANK, SCAN, DRAW} ppu_mode_t;

  // Native-width FIFO entry; the FIFO itself re-declares this shape at its own PX_W.
  typedef struct packed {
    logic [PPU_PX_W-1:0] bg_raw;
    logic [PPU_PX_W-1:0] obj_raw;
    logic                obj_pal;
    logic                obj_prio;
  } px_entry_t;

  function automatic int pal_entries(input int px_w);
    return 1 << px_w;
  endfunction

endpackage

// File: rtl/ppu_pixel_fifo_if.sv
// Row push, object merge and pixel output handshakes of the pixel FIFO.
interface ppu_pixel_fifo_if #(
  parameter int TILE_W = 8,
  parameter int PX_W   = 2
);
  logic                     row_valid;
  logic                     row_ready;
  logic [PX_W*TILE_W-1:0]   row_planes;
  logic                     obj_valid;
  logic                     obj_ready;
  logic [PX_W*TILE_W-1:0]   obj_planes;
  logic                     obj_pal;
  logic                     obj_prio;
  logic                     px_valid;
  logic                     px_ready;
  logic [PX_W-1:0]          px_color;

  modport master (
    output row_valid, row_planes, obj_valid, obj_planes, obj_pal, obj_prio, px_ready,
    input  row_ready, obj_ready, px_valid, px_color
  );

  modport slave (
    input  row_valid, row_planes, obj_valid, obj_planes, obj_pal, obj_prio, px_ready,
    output row_ready, obj_ready, px_valid, px_color
  );
endinterface

// File: rtl/ppu_pixel_fifo_palette_lut.sv
// Combinational palette lookup: raw pixel index -> shade.
module ppu_palette_lut
  import ppu_pixel_fifo_pkg::*;
#(
  parameter int PX_W = 2
) (
  input  logic [PX_W*(2**PX_W)-1:0] pal,
  input  logic [PX_W-1:0]           idx,
  output logic [PX_W-1:0]           shade
);
  localparam int NE = pal_entries(PX_W);

  logic [NE-1:0][PX_W-1:0] ent;

  assign ent   = pal;
  assign shade = ent[idx];
endmodule

// File: rtl/ppu_pixel_fifo.sv
// Pixel FIFO between BG fetcher and LCD: tile-row push, object merge at head,
// fine-scroll discard and palette-mapped output.
module ppu_pixel_fifo
  import ppu_pixel_fifo_pkg::*;
#(
  parameter int TILE_W = PPU_TILE_W,
  parameter int DEPTH  = PPU_DEPTH,
  parameter int PX_W   = PPU_PX_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          discard_load,
  input  logic [$clog2(TILE_W)-1:0]     discard_cnt,
  input  logic                          bg_en,
  input  logic [PX_W*(2**PX_W)-1:0]     bgp,
  input  logic [PX_W*(2**PX_W)-1:0]     obp0,
  input  logic [PX_W*(2**PX_W)-1:0]     obp1,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  ppu_pixel_fifo_if.slave               bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int DW = $clog2(TILE_W);

  typedef struct packed {
    logic [PX_W-1:0] bg_raw;
    logic [PX_W-1:0] obj_raw;
    logic            obj_pal;
    logic            obj_prio;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   rem_q;

  logic push_fire, merge_fire, pop, drop, adv;
  logic [TILE_W-1:0][PX_W-1:0] row_raw, obj_raw;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  // Bit TILE_W-1 of each plane is the leftmost pixel (slot 0).
  always_comb begin
    row_raw = '0;
    obj_raw = '0;
    for (int i = 0; i < TILE_W; i++) begin
      for (int p = 0; p < PX_W; p++) begin
        row_raw[i][p] = bus.row_planes[p*TILE_W + TILE_W-1-i];
        obj_raw[i][p] = bus.obj_planes[p*TILE_W + TILE_W-1-i];
      end
    end
  end

  assign bus.row_ready = !flush && (cnt_q <= CW'(DEPTH-TILE_W));
  assign bus.obj_ready = !flush && (cnt_q >= CW'(TILE_W));
  assign push_fire     = bus.row_valid && bus.row_ready;
  assign merge_fire    = bus.obj_valid && bus.obj_ready;
  assign bus.px_valid  = !flush && (cnt_q != '0) && (rem_q == '0) && !merge_fire;
  assign pop           = bus.px_valid && bus.px_ready;
  assign drop          = !flush && (rem_q != '0) && (cnt_q != '0) && !merge_fire;
  assign adv           = pop || drop;
  assign count         = cnt_q;

  // Storage and pointers; push fills the tail while merge rewrites the head,
  // which never overlap because push needs TILE_W free slots.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
      rem_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_fire) begin
        for (int i = 0; i < TILE_W; i++)
          mem[wrap_add(wr_ptr, i)] <= '{bg_raw: row_raw[i], obj_raw: '0, obj_pal: 1'b0, obj_prio: 1'b0};
        wr_ptr <= wrap_add(wr_ptr, TILE_W);
      end
      if (merge_fire) begin
        for (int i = 0; i < TILE_W; i++) begin
          if (mem[wrap_add(rd_ptr, i)].obj_raw == '0 && obj_raw[i] != '0) begin
            mem[wrap_add(rd_ptr, i)].obj_raw  <= obj_raw[i];
            mem[wrap_add(rd_ptr, i)].obj_pal  <= bus.obj_pal;
            mem[wrap_add(rd_ptr, i)].obj_prio <= bus.obj_prio;
          end
        end
      end
      if (adv) rd_ptr <= wrap_add(rd_ptr, 1);
      cnt_q <= cnt_q + (push_fire ? CW'(TILE_W) : CW'(0)) - CW'(adv);
      if (discard_load)  rem_q <= discard_cnt;
      else if (drop)     rem_q <= rem_q - DW'(1);
    end
  end

  entry_t          head;
  logic [PX_W-1:0] bgr, bg_shade, obj_shade;
  logic [PX_W*(2**PX_W)-1:0] obj_pal_sel;
  logic            use_obj;

  assign head        = mem[rd_ptr];
  assign bgr         = bg_en ? head.bg_raw : '0;
  assign obj_pal_sel = head.obj_pal ? obp1 : obp0;
  assign use_obj     = (head.obj_raw != '0) && !(head.obj_prio && bgr != '0);

  ppu_palette_lut #(.PX_W(PX_W)) u_bg_lut  (.pal(bgp),         .idx(bgr),          .shade(bg_shade));
  ppu_palette_lut #(.PX_W(PX_W)) u_obj_lut (.pal(obj_pal_sel), .idx(head.obj_raw), .shade(obj_shade));

  assign bus.px_color = !bus.px_valid ? '0 : (use_obj ? obj_shade : bg_shade);

endmodule
